instr_byte_assembler: RTL and testbench
=======================================

// Module: instr_byte_assembler
// PURPOSE
//  Packs a stream of instruction bytes from the fetch path into one
//  MAX_BYTES*BYTE_W-bit instruction word of variable length (1..MAX_BYTES).
//  Both sides use valid/ready handshakes, so the word is held until decode
//  accepts it. Sits between the byte fetch interface and the decoder.
//  First byte lands in the MS lane; unused lanes read as zero.
// PARAMETERS
//  BYTE_W      8   width of one input byte lane
//  MAX_BYTES   3   max bytes per instruction (>=1); out_instr = MAX_BYTES*BYTE_W
//  TIMEOUT_CYC 16  idle cycles before a partial word is force-committed (timeout build only)
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  flush      in   1                  sync discard of partial/held word (pipeline redirect)
//  in_valid   in   1                  in_data valid
//  in_data    in   BYTE_W             next instruction byte
//  in_last    in   1                  in_data is final byte of this instruction
//  in_ready   out  1                  assembler accepts byte this cycle
//  out_valid  out  1                  out_instr/out_len/out_trunc valid
//  out_ready  in   1                  decoder accepts word
//  out_instr  out  MAX_BYTES*BYTE_W   assembled word, byte k at [W-1-k*BYTE_W -: BYTE_W]
//  out_len    out  $clog2(MAX_BYTES+1) bytes in word (1..MAX_BYTES)
//  out_trunc  out  1                  word committed without in_last (overflow/timeout)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=FILL, count=0, out_instr=0, out_len=0,
//    out_trunc=0, out_valid=0; in_ready=0 while rst is high.
//  - Byte accept: in_valid&&in_ready. Word handoff: out_valid&&out_ready.
//  - FILL: in_ready=1, out_valid=0. On accept, lane[count]<=in_data.
//    - in_last=1 -> HOLD, out_len=count+1, out_trunc=0.
//    - in_last=0 and count==MAX_BYTES-1 -> HOLD, out_len=MAX_BYTES,
//      out_trunc=1 (overflow); the next byte starts a new word.
//    - otherwise count<=count+1.
//  - HOLD: out_valid=1, outputs stable until handoff; in_ready=out_ready.
//    - handoff w/o accept -> FILL, count=0, all lanes cleared.
//    - handoff + accept same cycle -> lanes cleared, lane0<=in_data, count=1;
//      if in_last or MAX_BYTES==1, stay HOLD with out_len=1; else FILL.
//  - Latency: word valid the cycle after its last byte is accepted;
//    sustained 1 byte/cycle with out_ready held high.
//  - flush=1: next state FILL, count=0, lanes=0, out_valid=0, out_len=0,
//    out_trunc=0; in_ready=0 that cycle; any in_valid byte dropped.
//    rst beats flush; flush beats accept/handoff.
//  - out_len==0 only while out_valid=0.
// CONFIGURATION
//  IBA_TIMEOUT_EN defined: idle counter runs in FILL when count>0, cleared
//    on any accept/flush/rst. At TIMEOUT_CYC consecutive non-accept cycles,
//    commit partial: HOLD, out_len=count, out_trunc=1.
//  IBA_TIMEOUT_EN undefined: no counter; partial word waits indefinitely;
//    TIMEOUT_CYC unused. All other behaviour identical.
// TESTING
//  1 Reset: rst=1 two cycles -> out_valid=0, out_instr=0, out_len=0, in_ready=0;
//    rst=0 -> in_ready=1.
//  2 3-byte word: AA,BB,CC(last), out_ready=1 -> next cycle
//    out_instr=24'hAABBCC, out_len=3, out_trunc=0, single-cycle valid.
//  3 Short word + backpressure: 12(last), out_ready=0 for 4 cycles ->
//    out_instr=24'h120000 stable, out_len=1, in_ready=0, no byte lost.
//  4 Back-to-back: 1-byte words 01..05 every cycle, out_ready=1 ->
//    five words, one per cycle, no bubbles, order preserved.
//  5 Overflow: 11,22,33 all in_last=0, then 44(last) ->
//    word1=24'h112233 trunc=1 len=3; word2=24'h440000 trunc=0 len=1.
//  6 Flush: 55,66 accepted, flush=1 -> out_valid stays 0; then 77(last)
//    -> 24'h770000 len=1. Timeout build: 88 then idle TIMEOUT_CYC ->
//    24'h880000 len=1 trunc=1.

Source files
------------

// File: rtl/instr_byte_assembler_if.sv
// Byte-in / word-out handshake bundle between fetch, the assembler and decode.
// Latency: none (wires only).
// Backpressure: in_ready throttles fetch, out_ready throttles the assembler.
interface instr_byte_assembler_if #(
    parameter int BYTE_W    = 8,
    parameter int MAX_BYTES = 3
);
    localparam int W  = MAX_BYTES * BYTE_W;
    localparam int LW = $clog2(MAX_BYTES + 1);

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_instr;
    logic [LW-1:0]     out_len;
    logic              out_trunc;

    // Fetch and decode side: drives bytes in, accepts words out.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_len, out_trunc
    );

    // Assembler side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_len, out_trunc
    );
endinterface

// File: rtl/instr_byte_assembler.sv
// Packs instruction bytes (first byte in MS lane) into one word of 1..MAX_BYTES bytes.
// Latency: word valid the cycle after its last byte is accepted; 1 byte/cycle sustained.
// Backpressure: word held until out_ready; while held, in_ready follows out_ready.
// Optional build macro IBA_TIMEOUT_EN: force-commit a partial word after TIMEOUT_CYC idle cycles.
module instr_byte_assembler #(
    parameter int BYTE_W      = 8,
    parameter int MAX_BYTES   = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    instr_byte_assembler_if.slave         bus
);
    localparam int W  = MAX_BYTES * BYTE_W;
    localparam int LW = $clog2(MAX_BYTES + 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [W-1:0]  lanes_q, lanes_d;
    logic [LW-1:0] len_q, len_d;
    logic          trunc_q, trunc_d;
    logic          accept;
    logic          handoff;

`ifdef IBA_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_q, idle_d;
`else
    // The timeout length is only meaningful when the timeout logic is built.
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Handshake outputs: nothing is accepted during reset or a flush cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = (state_q == HOLD);
        if (!rst && !flush)
            bus.in_ready = (state_q == FILL) ? 1'b1 : bus.out_ready;
    end

    assign accept        = bus.in_valid && bus.in_ready;
    assign handoff       = bus.out_valid && bus.out_ready;
    assign bus.out_instr = lanes_q;
    assign bus.out_len   = len_q;
    assign bus.out_trunc = trunc_q;

    // Next-state: flush wins over accept/handoff; rst is applied in the register.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lanes_d = lanes_q;
        len_d   = len_q;
        trunc_d = trunc_q;
`ifdef IBA_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        if (flush) begin
            state_d = FILL;
            count_d = '0;
            lanes_d = '0;
            len_d   = '0;
            trunc_d = 1'b0;
`ifdef IBA_TIMEOUT_EN
            idle_d  = '0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
`ifdef IBA_TIMEOUT_EN
                        idle_d = '0;
`endif
                        for (int k = 0; k < MAX_BYTES; k++)
                            if (count_q == LW'(k))
                                lanes_d[W-1-k*BYTE_W -: BYTE_W] = bus.in_data;
                        if (bus.in_last) begin
                            state_d = HOLD;
                            len_d   = count_q + LW'(1);
                            trunc_d = 1'b0;
                            count_d = '0;
                        end else if (count_q == LW'(MAX_BYTES - 1)) begin
                            // Overflow: commit a full word flagged truncated.
                            state_d = HOLD;
                            len_d   = LW'(MAX_BYTES);
                            trunc_d = 1'b1;
                            count_d = '0;
                        end else begin
                            count_d = count_q + LW'(1);
                        end
                    end
`ifdef IBA_TIMEOUT_EN
                    else if (count_q != '0) begin
                        if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
                            state_d = HOLD;
                            len_d   = count_q;
                            trunc_d = 1'b1;
                            count_d = '0;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
`endif
                end
                HOLD: begin
                    if (handoff) begin
                        lanes_d = '0;
                        count_d = '0;
                        len_d   = '0;
                        trunc_d = 1'b0;
                        state_d = FILL;
                        if (accept) begin
                            // Start the next word in the same cycle the held one leaves.
                            lanes_d[W-1 -: BYTE_W] = bus.in_data;
                            count_d = LW'(1);
                            if (bus.in_last || MAX_BYTES == 1) begin
                                state_d = HOLD;
                                len_d   = LW'(1);
                                trunc_d = !bus.in_last;
                                count_d = '0;
                            end
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            lanes_q <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lanes_q <= lanes_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef IBA_TIMEOUT_EN
    // Idle counter for the partial-word timeout.
    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`endif
endmodule

// File: tb/tb_instr_byte_assembler.sv
// Directed self-checking bench for instr_byte_assembler (BYTE_W=8, MAX_BYTES=3).
// Latency: inputs change and outputs are sampled 1 time unit after the rising edge.
// Backpressure: exercised by holding out_ready low while a word is pending.
module tb_instr_byte_assembler;
    localparam int BYTE_W      = 8;
    localparam int MAX_BYTES   = 3;
    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_byte_assembler_if #(.BYTE_W(BYTE_W), .MAX_BYTES(MAX_BYTES)) bus ();

    instr_byte_assembler #(
        .BYTE_W(BYTE_W), .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held two cycles.
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", 32'(bus.out_instr), 32'h0);
        chk("rst_out_len",   32'(bus.out_len),   32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 3-byte word with decoder ready.
        bus.out_ready = 1'b1;
        drive(1'b1, 8'hAA, 1'b0); tick();
        chk("w3_no_early_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 8'hBB, 1'b0); tick();
        drive(1'b1, 8'hCC, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("w3_valid", 32'(bus.out_valid), 32'd1);
        chk("w3_instr", 32'(bus.out_instr), 32'hAABBCC);
        chk("w3_len",   32'(bus.out_len),   32'd3);
        chk("w3_trunc", 32'(bus.out_trunc), 32'd0);
        tick();
        chk("w3_single_cycle", 32'(bus.out_valid), 32'd0);

        // Short word held under backpressure; a waiting byte must not be taken.
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h12, 1'b1); tick();
        drive(1'b1, 8'h34, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid",    32'(bus.out_valid), 32'd1);
            chk("bp_instr",    32'(bus.out_instr), 32'h120000);
            chk("bp_len",      32'(bus.out_len),   32'd1);
            chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("bp_next_instr", 32'(bus.out_instr), 32'h340000);
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back 1-byte words, one per cycle.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            tick();
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_instr", 32'(bus.out_instr), 32'(i) << 16);
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        chk("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Overflow: three bytes without last, then a 1-byte word.
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        chk("ovf_instr", 32'(bus.out_instr), 32'h112233);
        chk("ovf_len",   32'(bus.out_len),   32'd3);
        chk("ovf_trunc", 32'(bus.out_trunc), 32'd1);
        drive(1'b1, 8'h44, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf2_instr", 32'(bus.out_instr), 32'h440000);
        chk("ovf2_len",   32'(bus.out_len),   32'd1);
        chk("ovf2_trunc", 32'(bus.out_trunc), 32'd0);
        tick();

        // Flush discards a partial word and drops the byte offered that cycle.
        drive(1'b1, 8'h55, 1'b0); tick();
        drive(1'b1, 8'h66, 1'b0); tick();
        flush = 1'b1;
        drive(1'b1, 8'h99, 1'b1);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_len",   32'(bus.out_len),   32'd0);
        tick();
        chk("flush_dropped", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 8'h77, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("post_flush_instr", 32'(bus.out_instr), 32'h770000);
        chk("post_flush_len",   32'(bus.out_len),   32'd1);
        tick();

        // Flush also discards a held word.
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hAB, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_hold_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_hold_instr", 32'(bus.out_instr), 32'h0);
        bus.out_ready = 1'b1;

        // Partial word left idle.
        drive(1'b1, 8'h88, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
`ifdef IBA_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        chk("to_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        chk("to_valid", 32'(bus.out_valid), 32'd1);
        chk("to_instr", 32'(bus.out_instr), 32'h880000);
        chk("to_len",   32'(bus.out_len),   32'd1);
        chk("to_trunc", 32'(bus.out_trunc), 32'd1);
        tick();
`else
        for (int i = 0; i < TIMEOUT_CYC + 4; i++) tick();
        chk("idle_wait_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 8'h99, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("idle_resume_instr", 32'(bus.out_instr), 32'h889900);
        chk("idle_resume_len",   32'(bus.out_len),   32'd2);
        chk("idle_resume_trunc", 32'(bus.out_trunc), 32'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
